delay_arbiter: RTL and testbench
================================

DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the delay timer (legal 2..8).
REQ-002 Parameter CNT_WIDTH, default 16, width of each requester's delay value in clock cycles.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port resetn  input  1  reset; one clock, asynchronous, active-low reset.
REQ-005 Port req  input  NUM_REQ  per-requester request level; bit i owned by requester i.
REQ-006 Port delay_in  input  NUM_REQ*CNT_WIDTH  delay for requester i in bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-007 Port grant  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-008 Port done  output  NUM_REQ  one-hot, one-cycle expiry pulse to the granted requester.
REQ-009 Port busy  output  1  high whenever the shared timer is in use.
REQ-010 Port active_id  output  $clog2(NUM_REQ)  index of the most recently granted requester.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, COUNT and DONE.
REQ-012 All outputs SHALL be registered.
REQ-013 IDLE with req == 0: the FSM SHALL remain in IDLE, with grant, done and busy at 0.
REQ-014 IDLE with req != 0 at an edge: that edge SHALL select winner w by round-robin, set grant[w]=1, active_id=w and busy=1, load counter with delay_in slice w, and enter COUNT.
REQ-015 Round-robin SHALL search ascending from pointer ptr with wrap; ptr SHALL become (w+1) mod NUM_REQ on every grant.
REQ-016 grant SHALL be high for exactly one cycle; req is sampled only in IDLE.
REQ-017 A requester still holding req after its grant SHALL be treated as a new request at the next IDLE.
REQ-018 In COUNT, each edge with counter != 0 SHALL decrement the counter.
REQ-019 In COUNT, an edge with counter == 0 SHALL enter DONE and set done[w]=1.
REQ-020 done SHALL appear exactly D+1 cycles after grant for delay D; D=0 gives done 1 cycle after grant.
REQ-021 Maximum D (2^CNT_WIDTH-1) SHALL count fully; the counter SHALL never wrap.
REQ-022 DONE SHALL last one cycle, then enter IDLE with done=0 and busy=0.
REQ-023 A new grant SHALL be possible on the edge after leaving DONE, giving a grant-to-grant spacing of D+3 cycles.
REQ-024 delay_in and req changes outside the grant edge SHALL have no effect on an in-flight count.

Reset
REQ-025 resetn low SHALL asynchronously force state IDLE, grant=0, done=0, busy=0, active_id=0, counter=0 and ptr=0.
REQ-026 Reset mid-COUNT or mid-DONE SHALL discard the pending done with no pulse.
REQ-027 After resetn deasserts, the first grant SHALL favour index 0.

Configuration
REQ-028 Macro DELAY_ARBITER_ABORT_EN defined: an extra input port abort (1 bit) SHALL exist.
REQ-029 With the macro, abort high at an edge in COUNT SHALL enter IDLE, clear busy and never assert done.
REQ-030 With the macro, abort SHALL be ignored in IDLE and DONE, and ptr SHALL keep the advance made at grant.
REQ-031 Macro undefined: the abort port SHALL be absent and no abort logic compiled.

Verification
REQ-032 Reset, then req=4'b0001, delay0=4 -> grant[0] one cycle; done[0] exactly 5 cycles later; busy high for 6 cycles.
REQ-033 req=4'b1111 held, all delays=0 -> grants in order 0,1,2,3,0; each done 1 cycle after its grant; grant-to-grant spacing 3 cycles.
REQ-034 req=4'b0101, delays 2 and 7 -> grant[0], done[0] at +3; grant[2] 1 cycle after DONE; done[2] 8 cycles after grant[2].
REQ-035 Grant requester 1 with delay 10, pull resetn low 4 cycles later -> outputs 0 immediately, no done[1]; next request from 2 and 3 together grants 2... (ptr=0 search finds 2).
REQ-036 With DELAY_ARBITER_ABORT_EN: grant 3 with delay 20, abort at cycle 5 -> IDLE next edge, done stays 0; next req=4'b1001 grants 0.

Source files
------------

// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin arbiter sharing one down-counting delay timer
// among NUM_REQ requesters. A grant loads the winner's delay; done pulses
// to the winner D+1 cycles after its grant.
// Optional feature: define DELAY_ARBITER_ABORT_EN to add an abort input that
// cancels an in-flight count without a done pulse.
module delay_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
`ifdef DELAY_ARBITER_ABORT_EN
  input  logic                           abort,
`endif
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]   delay_in,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     active_id
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [IDW-1:0]       ptr, ptr_nxt;
  logic [NUM_REQ-1:0]   grant_nxt, done_nxt;
  logic                 busy_nxt;
  logic [IDW-1:0]       id_nxt;

  logic                 hi_found, lo_found;
  logic [IDW-1:0]       hi_w, lo_w, win;
  logic [CNT_WIDTH-1:0] hi_d, lo_d, win_delay;

  // Round-robin pick: first request at or above ptr, else first request overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_w     = '0;
    lo_w     = '0;
    hi_d     = '0;
    lo_d     = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (req[j] && !hi_found && (IDW'(j) >= ptr)) begin
        hi_found = 1'b1;
        hi_w     = IDW'(j);
        hi_d     = delay_in[j*CNT_WIDTH +: CNT_WIDTH];
      end
      if (req[j] && !lo_found) begin
        lo_found = 1'b1;
        lo_w     = IDW'(j);
        lo_d     = delay_in[j*CNT_WIDTH +: CNT_WIDTH];
      end
    end
    win       = hi_found ? hi_w : lo_w;
    win_delay = hi_found ? hi_d : lo_d;
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    grant_nxt = '0;
    done_nxt  = '0;
    busy_nxt  = busy;
    id_nxt    = active_id;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (|req) begin
          grant_nxt = ONE_HOT0 << win;
          id_nxt    = win;
          busy_nxt  = 1'b1;
          cnt_nxt   = win_delay;
          ptr_nxt   = (win == LAST_ID) ? '0 : win + IDW'(1);
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        busy_nxt = 1'b1;
`ifdef DELAY_ARBITER_ABORT_EN
        if (abort) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else
`endif
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_WIDTH'(1);
        end else begin
          done_nxt  = ONE_HOT0 << active_id;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, timer, pointer and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      active_id <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      active_id <= id_nxt;
    end
  end

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed self-checking bench for delay_arbiter (NUM_REQ=4, CNT_WIDTH=16).
// Abort scenario is compiled only when DELAY_ARBITER_ABORT_EN is defined.
module tb_delay_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 16;

  logic               clk;
  logic               resetn;
  logic [NR-1:0]      req;
  logic [NR*CW-1:0]   delay_in;
  logic [NR-1:0]      grant;
  logic [NR-1:0]      done;
  logic               busy;
  logic [1:0]         active_id;
`ifdef DELAY_ARBITER_ABORT_EN
  logic               abort;
`endif

  int n_cmp;
  int n_err;

  delay_arbiter #(.NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .resetn    (resetn),
`ifdef DELAY_ARBITER_ABORT_EN
    .abort     (abort),
`endif
    .req       (req),
    .delay_in  (delay_in),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .active_id (active_id)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_delay(input int idx, input logic [CW-1:0] d);
    delay_in[idx*CW +: CW] = d;
  endtask

  // Asynchronous reset pulse, checked before any clock edge arrives
  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #1;
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_done"},  32'(done),  32'h0);
    chk({tag, "_busy"},  32'(busy),  32'h0);
    chk({tag, "_id"},    32'(active_id), 32'h0);
    step();
    resetn = 1'b1;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    resetn   = 1'b1;
    req      = '0;
    delay_in = '0;
`ifdef DELAY_ARBITER_ABORT_EN
    abort    = 1'b0;
`endif
    #1;
    do_reset("rst0");

    // Single requester, D=4: done 5 cycles after grant, busy 6 cycles
    req = 4'b0001;
    set_delay(0, 16'd4);
    step();
    chk("s1_grant", 32'(grant), 32'h1);
    chk("s1_busy0", 32'(busy), 32'h1);
    chk("s1_id", 32'(active_id), 32'h0);
    req = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("s1_cnt_done", 32'(done), 32'h0);
      chk("s1_cnt_busy", 32'(busy), 32'h1);
      chk("s1_cnt_grant", 32'(grant), 32'h0);
    end
    step();
    chk("s1_done", 32'(done), 32'h1);
    chk("s1_busy5", 32'(busy), 32'h1);
    step();
    chk("s1_done_off", 32'(done), 32'h0);
    chk("s1_busy_off", 32'(busy), 32'h0);
    step();
    chk("s1_idle_grant", 32'(grant), 32'h0);

    // All requesting, D=0: rotation 0,1,2,3,0 with 3-cycle spacing
    do_reset("rst1");
    delay_in = '0;
    req = 4'b1111;
    begin
      int order [5];
      order = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        step();
        chk("s2_grant", 32'(grant), 32'(1) << order[k]);
        chk("s2_id", 32'(active_id), 32'(order[k]));
        step();
        chk("s2_done", 32'(done), 32'(1) << order[k]);
        chk("s2_grant_off", 32'(grant), 32'h0);
        if (k == 4) req = 4'b0000;
        step();
        chk("s2_idle_done", 32'(done), 32'h0);
        chk("s2_idle_busy", 32'(busy), 32'h0);
      end
    end

    // req=0101, delays 2 and 7; in-flight delay_in changes are ignored
    do_reset("rst2");
    req = 4'b0101;
    set_delay(0, 16'd2);
    set_delay(2, 16'd7);
    step();
    chk("s3_grant0", 32'(grant), 32'h1);
    step();
    chk("s3_t1_done", 32'(done), 32'h0);
    step();
    chk("s3_t2_done", 32'(done), 32'h0);
    step();
    chk("s3_done0", 32'(done), 32'h1);
    step();
    chk("s3_idle_busy", 32'(busy), 32'h0);
    chk("s3_idle_grant", 32'(grant), 32'h0);
    step();
    chk("s3_grant2", 32'(grant), 32'h4);
    chk("s3_id2", 32'(active_id), 32'h2);
    req = 4'b0000;
    delay_in = '1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("s3_cnt_done", 32'(done), 32'h0);
      chk("s3_cnt_busy", 32'(busy), 32'h1);
    end
    step();
    chk("s3_done2", 32'(done), 32'h4);
    step();
    chk("s3_end_busy", 32'(busy), 32'h0);

    // Reset mid-count discards done; next grant searches from index 0
    delay_in = '0;
    req = 4'b0010;
    set_delay(1, 16'd10);
    step();
    chk("s4_grant1", 32'(grant), 32'h2);
    req = 4'b0000;
    for (int k = 0; k < 4; k++) step();
    chk("s4_pre_busy", 32'(busy), 32'h1);
    resetn = 1'b0;
    #2;
    chk("s4_rst_busy", 32'(busy), 32'h0);
    chk("s4_rst_grant", 32'(grant), 32'h0);
    chk("s4_rst_id", 32'(active_id), 32'h0);
    step();
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("s4_no_done", 32'(done), 32'h0);
    end
    req = 4'b1100;
    set_delay(2, 16'd1);
    step();
    chk("s4_grant2", 32'(grant), 32'h4);
    chk("s4_id2", 32'(active_id), 32'h2);
    req = 4'b0000;
    step();
    step();
    chk("s4_done2", 32'(done), 32'h4);
    step();

`ifdef DELAY_ARBITER_ABORT_EN
    // Abort mid-count returns to IDLE without done; ptr keeps its advance
    do_reset("rst3");
    req = 4'b1000;
    set_delay(3, 16'd20);
    step();
    chk("s5_grant3", 32'(grant), 32'h8);
    req = 4'b0000;
    for (int k = 0; k < 4; k++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s5_abort_busy", 32'(busy), 32'h0);
    chk("s5_abort_done", 32'(done), 32'h0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("s5_no_done", 32'(done), 32'h0);
    end
    req = 4'b1001;
    step();
    chk("s5_grant0", 32'(grant), 32'h1);
    req = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
